// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel types and constants.
// Used by the SRAM read responder and its FIFOs.
package axi_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int DATA_BYTE = DATA_W / 8;
  localparam int BYTE_SH   = $clog2(DATA_BYTE);

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              err;
  } ArReq;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } RBeat;

  // Byte mask of one wrap block: (len+1)<<size - 1.
  function automatic logic [ADDR_W-1:0] wrap_mask(
    input logic [7:0] len,
    input logic [2:0] size
  );
    return ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
  endfunction

endpackage

// File: rtl/axi_rd_responder_fifo.sv
// Synchronous FIFO with registered storage and combinational head.
// DEPTH must be a power of two.
module sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              wdata_i,
  input  logic          pop_i,
  output T              rdata_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
    if (!rst) begin
      assert (!(push_i && !pop_i && cnt_q == CW'(DEPTH)))
        else $error("sync_fifo overflow");
      assert (!(pop_i && cnt_q == '0))
        else $error("sync_fifo underflow");
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder in front of a 1-cycle-latency SRAM.
// In-order FIXED/INCR/WRAP bursts with r_ready backpressure.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                MEM_AW     = 14,
  parameter logic [ADDR_W-1:0] MEM_BASE   = '0,
  parameter int                AR_DEPTH   = 2,
  parameter int                RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int ACW = $clog2(AR_DEPTH) + 1;
  localparam int RCW = $clog2(RESP_DEPTH) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [ADDR_W:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_W:0] WIN_HI =
    WIN_LO + ((ADDR_W+1)'(1) << (MEM_AW + BYTE_SH));

  function automatic logic in_win(input logic [ADDR_W:0] a);
    return (a >= WIN_LO) && (a < WIN_HI);
  endfunction

  // Request classification at enqueue
  logic [ADDR_W-1:0] ar_mask;
  logic [ADDR_W:0]   ar_first, ar_lasta;
  logic              wrap_ok, ar_err, ar_push;
  ArReq              ar_req;

  always_comb begin
    ar_mask  = wrap_mask(ar_len, ar_size);
    wrap_ok  = ar_len inside {8'd1, 8'd3, 8'd7, 8'd15};
    ar_first = {1'b0, ar_addr};
    unique case (ar_burst)
      AXI_BURST_FIXED: ar_lasta = ar_first;
      AXI_BURST_WRAP:  ar_lasta = {1'b0, (ar_addr & ~ar_mask) |
        ((ar_addr + (ADDR_W'(ar_len) << ar_size)) & ar_mask)};
      default: ar_lasta =
        ar_first + ((ADDR_W+1)'(ar_len) << ar_size);
    endcase
    ar_err = (ar_size > 3'(BYTE_SH))
           | (ar_burst == 2'b11)
           | ((ar_burst == AXI_BURST_WRAP) & ~wrap_ok)
           | ~in_win(ar_first)
           | ~in_win(ar_lasta);
  end

  assign ar_req = '{id: ar_id, addr: ar_addr, len: ar_len,
                    size: ar_size, burst: ar_burst, err: ar_err};

  logic [ACW-1:0] arq_cnt;
  logic [RCW-1:0] resp_cnt;
  ArReq           head;
  RBeat           rhead, rbeat;
  logic           ar_pop, r_pop;

  assign ar_ready = (arq_cnt != ACW'(AR_DEPTH));
  assign ar_push  = ar_valid & ar_ready;

  sync_fifo #(.T(ArReq), .DEPTH(AR_DEPTH)) u_arq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ar_push),
    .wdata_i (ar_req),
    .pop_i   (ar_pop),
    .rdata_o (head),
    .count_o (arq_cnt)
  );

  // Beat generator
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, beat_addr, next_addr;
  logic [ADDR_W-1:0] step, mask;
  logic [7:0]        cnt_q, cnt_d, beat_cnt;
  logic              s1_valid_q, s1_err_q, s1_last_q;
  logic [ID_W-1:0]   s1_id_q;
  logic              active, credit, issue, is_last;

  assign r_valid = (resp_cnt != '0);
  assign r_pop   = r_valid & r_ready;

  always_comb begin
    active    = (arq_cnt != '0);
    beat_addr = (state_q == S_BURST) ? cur_q : head.addr;
    beat_cnt  = (state_q == S_BURST) ? cnt_q : 8'd0;
    // Reserve a slot for the beat already in the SRAM stage
    credit    = (int'(resp_cnt) + int'(s1_valid_q) - int'(r_pop))
                < RESP_DEPTH;
    issue     = active & credit;
    is_last   = (beat_cnt == head.len);
    ar_pop    = issue & is_last;
    step      = ADDR_W'(1) << head.size;
    mask      = wrap_mask(head.len, head.size);
    unique case (head.burst)
      AXI_BURST_FIXED: next_addr = beat_addr;
      AXI_BURST_WRAP:  next_addr = (beat_addr & ~mask) |
                                   ((beat_addr + step) & mask);
      default:         next_addr = beat_addr + step;
    endcase
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    if (issue) begin
      if (is_last) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_BURST;
        cur_d   = next_addr;
        cnt_d   = beat_cnt + 8'd1;
      end
    end
  end

  assign mem_en   = issue & ~head.err;
  assign mem_addr = MEM_AW'((beat_addr - MEM_BASE) >> BYTE_SH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= issue;
      s1_err_q   <= head.err;
      s1_last_q  <= is_last;
      s1_id_q    <= head.id;
    end
  end

  assign rbeat = '{id:   s1_id_q,
                   data: s1_err_q ? '0 : mem_rdata,
                   resp: s1_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY,
                   last: s1_last_q};

  sync_fifo #(.T(RBeat), .DEPTH(RESP_DEPTH)) u_rbuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s1_valid_q),
    .wdata_i (rbeat),
    .pop_i   (r_pop),
    .rdata_o (rhead),
    .count_o (resp_cnt)
  );

  assign r_id   = r_valid ? rhead.id   : '0;
  assign r_data = r_valid ? rhead.data : '0;
  assign r_resp = r_valid ? rhead.resp : '0;
  assign r_last = r_valid & rhead.last;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder with a behavioural SRAM.
module tb_axi_rd_responder;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  axi_rd_responder dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pat(input logic [13:0] w);
    return 32'h5A00_0000 ^ ({18'd0, w} * 32'h0001_0003);
  endfunction

  always_ff @(posedge clk) if (mem_en) mem_rdata <= pat(mem_addr);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       bq[$];
  int          hsq[$];
  int          ncyc = 0;
  int          men_cnt = 0;
  int          stall_cnt = 0;
  logic        stl = 1'b0;
  logic [38:0] stl_v;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      stl = 1'b0;
    end else begin
      if (mem_en) men_cnt++;
      if (ar_valid && ar_ready) hsq.push_back(ncyc);
      if (ar_valid && !ar_ready) stall_cnt++;
      if (stl)
        chk("r_hold", {r_valid, r_id, r_data, r_resp, r_last},
            {1'b1, stl_v});
      if (r_valid && r_ready)
        bq.push_back('{r_id, r_data, r_resp, r_last, ncyc});
      stl   = r_valid && !r_ready;
      stl_v = {r_id, r_data, r_resp, r_last};
    end
  end

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  resp;
    logic [13:0] w [4];
  } vec_t;

  vec_t vt [11];

  task automatic setv(input int i, input logic [3:0] id,
                      input logic [31:0] a, input logic [7:0] l,
                      input logic [2:0] s, input logic [1:0] b,
                      input logic [1:0] rp,
                      input logic [13:0] w0, input logic [13:0] w1,
                      input logic [13:0] w2, input logic [13:0] w3);
    vt[i].id = id;  vt[i].addr = a;  vt[i].len = l;
    vt[i].size = s; vt[i].burst = b; vt[i].resp = rp;
    vt[i].w[0] = w0; vt[i].w[1] = w1;
    vt[i].w[2] = w2; vt[i].w[3] = w3;
  endtask

  task automatic send(input logic [3:0] id, input logic [31:0] a,
                      input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] b);
    int h0;
    h0 = hsq.size();
    ar_id = id; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b;
    ar_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (hsq.size() > h0) break;
    end
    ar_valid = 1'b0;
    chk("ar_handshake", hsq.size() - h0, 1);
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 100 && bq.size() < n; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int hs, n;
    logic [31:0] ed;
    bq.delete();
    men_cnt = 0;
    n = int'(v.len) + 1;
    send(v.id, v.addr, v.len, v.size, v.burst);
    hs = hsq[$];
    wait_beats(n);
    chk({nm, "_nbeats"}, bq.size(), n);
    chk({nm, "_mem_en"}, men_cnt, (v.resp == AXI_RESP_OKAY) ? n : 0);
    for (int k = 0; k < n && k < bq.size(); k++) begin
      ed = (v.resp == AXI_RESP_OKAY) ? pat(v.w[k]) : 32'd0;
      chk($sformatf("%s_b%0d_id", nm, k), bq[k].id, v.id);
      chk($sformatf("%s_b%0d_data", nm, k), bq[k].data, ed);
      chk($sformatf("%s_b%0d_resp", nm, k), bq[k].resp, v.resp);
      chk($sformatf("%s_b%0d_last", nm, k), bq[k].last, k == n - 1);
      chk($sformatf("%s_b%0d_cyc", nm, k), bq[k].cyc - hs, 3 + k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_addr = '0;
    ar_len = '0; ar_size = '0; ar_burst = '0; r_ready = 1'b1;

    setv(0,  4'h5, 32'h100,   8'd3, 3'd2, 2'b01, 2'b00,
         14'h40, 14'h41, 14'h42, 14'h43);
    setv(1,  4'h6, 32'h108,   8'd3, 3'd2, 2'b10, 2'b00,
         14'h42, 14'h43, 14'h40, 14'h41);
    setv(2,  4'h7, 32'h108,   8'd2, 3'd2, 2'b10, 2'b10, 0, 0, 0, 0);
    setv(3,  4'h8, 32'h10000, 8'd1, 3'd2, 2'b01, 2'b10, 0, 0, 0, 0);
    setv(4,  4'h9, 32'h100,   8'd1, 3'd3, 2'b01, 2'b10, 0, 0, 0, 0);
    setv(5,  4'hA, 32'h200,   8'd0, 3'd2, 2'b01, 2'b00,
         14'h80, 0, 0, 0);
    setv(6,  4'hB, 32'hFFFC,  8'd1, 3'd2, 2'b01, 2'b10, 0, 0, 0, 0);
    setv(7,  4'hC, 32'hFFF8,  8'd1, 3'd2, 2'b01, 2'b00,
         14'h3FFE, 14'h3FFF, 0, 0);
    setv(8,  4'h1, 32'h40,    8'd2, 3'd2, 2'b00, 2'b00,
         14'h10, 14'h10, 14'h10, 0);
    setv(9,  4'h2, 32'h100,   8'd1, 3'd2, 2'b11, 2'b10, 0, 0, 0, 0);
    setv(10, 4'h3, 32'hFFF8,  8'd3, 3'd2, 2'b10, 2'b00,
         14'h3FFE, 14'h3FFF, 14'h3FFC, 14'h3FFD);

    #12;
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_mem_en", mem_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // r_ready toggling 1,0,0 across two queued bursts
    bq.delete();
    fork
      begin
        send(4'h1, 32'h100, 8'd3, 3'd2, AXI_BURST_INCR);
        send(4'h2, 32'h300, 8'd3, 3'd2, AXI_BURST_INCR);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          r_ready = (k % 3 == 0);
          @(posedge clk); #1;
        end
      end
    join
    r_ready = 1'b1;
    wait_beats(8);
    chk("tog_nbeats", bq.size(), 8);
    for (int k = 0; k < 8 && k < bq.size(); k++) begin
      chk($sformatf("tog_b%0d_id", k), bq[k].id, (k < 4) ? 1 : 2);
      chk($sformatf("tog_b%0d_data", k), bq[k].data,
          pat((k < 4) ? 14'(32'h40 + k) : 14'(32'hC0 + k - 4)));
      chk($sformatf("tog_b%0d_last", k), bq[k].last, k % 4 == 3);
    end

    // Full stall: generator stops once the buffer is full
    bq.delete();
    r_ready = 1'b0;
    men_cnt = 0;
    send(4'h4, 32'h400, 8'd7, 3'd2, AXI_BURST_INCR);
    repeat (12) @(posedge clk);
    #1;
    chk("stall_mem_en", men_cnt, 4);
    chk("stall_r_valid", r_valid, 1);
    r_ready = 1'b1;
    wait_beats(8);
    chk("stall_nbeats", bq.size(), 8);
    chk("stall_mem_total", men_cnt, 8);
    for (int k = 0; k < 8 && k < bq.size(); k++) begin
      chk($sformatf("stall_b%0d_data", k), bq[k].data,
          pat(14'(32'h100 + k)));
      chk($sformatf("stall_b%0d_last", k), bq[k].last, k == 7);
    end

    // Three back-to-back ARs against a 2-entry queue
    bq.delete();
    stall_cnt = 0;
    h0 = hsq.size();
    ar_valid = 1'b1; ar_len = 8'd3; ar_size = 3'd2;
    ar_burst = AXI_BURST_INCR;
    for (int i = 0; i < 3; i++) begin
      ar_id = 4'(i + 1);
      ar_addr = 32'h100 * (i + 1);
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (hsq.size() > h0 + i) break;
      end
    end
    ar_valid = 1'b0;
    wait_beats(12);
    chk("b2b_nhs", hsq.size() - h0, 3);
    chk("b2b_stall", stall_cnt, 3);
    if (hsq.size() == h0 + 3) begin
      chk("b2b_hs2", hsq[h0 + 1] - hsq[h0], 1);
      chk("b2b_hs3", hsq[h0 + 2] - hsq[h0], 5);
    end
    chk("b2b_nbeats", bq.size(), 12);
    for (int k = 0; k < 12 && k < bq.size(); k++) begin
      chk($sformatf("b2b_b%0d_id", k), bq[k].id, k / 4 + 1);
      chk($sformatf("b2b_b%0d_data", k), bq[k].data,
          pat(14'(32'h40 * (k / 4 + 1) + k % 4)));
      chk($sformatf("b2b_b%0d_last", k), bq[k].last, k % 4 == 3);
      if (hsq.size() > h0)
        chk($sformatf("b2b_b%0d_cyc", k), bq[k].cyc - hsq[h0], 3 + k);
    end

    // Reset after the first beat of a 4-beat burst
    bq.delete();
    r_ready = 1'b1;
    send(4'h3, 32'h100, 8'd3, 3'd2, AXI_BURST_INCR);
    for (int k = 0; k < 20 && bq.size() < 1; k++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_ar_ready", ar_ready, 1);
    chk("mid_rst_mem_en", mem_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_beats", bq.size(), 1);
    run_vec(vt[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
